// File: rtl/inst_cache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// The cache takes the slave modport; the fetcher/memory model takes master.
interface inst_cache_if;
  logic        IF_valid;
  logic [31:0] IF_addr;
  logic        IF_inst_valid;
  logic [31:0] IF_inst;
  logic        MemCtrl_inst_read_valid;
  logic [31:0] MemCtrl_inst_addr;
  logic        MemCtrl_inst_valid;
  logic [31:0] MemCtrl_inst;

  modport slave (
    input  IF_valid, IF_addr, MemCtrl_inst_valid, MemCtrl_inst,
    output IF_inst_valid, IF_inst, MemCtrl_inst_read_valid, MemCtrl_inst_addr
  );

  modport master (
    output IF_valid, IF_addr, MemCtrl_inst_valid, MemCtrl_inst,
    input  IF_inst_valid, IF_inst, MemCtrl_inst_read_valid, MemCtrl_inst_addr
  );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache with single-miss refill FSM.
// Optional ICACHE_MISS_FORWARD_EN returns refill data straight to the fetcher.
module inst_cache #(
  parameter int ICACHE_INDEX_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic clear,
  inst_cache_if.slave bus
);
  localparam int LINES = 1 << ICACHE_INDEX_W;
  localparam int TAG_W = 30 - ICACHE_INDEX_W;

`ifdef ICACHE_MISS_FORWARD_EN
  localparam bit MISS_FORWARD = 1'b1;
`else
  localparam bit MISS_FORWARD = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, MISS, ABORT} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic        fill_en;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem [LINES];
  logic [31:0]      data_mem [LINES];

  logic [ICACHE_INDEX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]          req_tag, fill_tag;
  logic                      hit;
  logic                      unused_addr_bits;

  assign req_idx  = bus.IF_addr[ICACHE_INDEX_W+1:2];
  assign req_tag  = bus.IF_addr[31:ICACHE_INDEX_W+2];
  assign fill_idx = addr_q[ICACHE_INDEX_W+1:2];
  assign fill_tag = addr_q[31:ICACHE_INDEX_W+2];
  assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign unused_addr_bits = ^{bus.IF_addr[1:0], addr_q[1:0]};

  // Drop the request in the strobe cycle so the controller never starts a second fetch.
  assign bus.MemCtrl_inst_read_valid = (state_q != IDLE) && !bus.MemCtrl_inst_valid;
  assign bus.MemCtrl_inst_addr       = addr_q;
  assign bus.IF_inst_valid           = inst_valid_q;
  assign bus.IF_inst                 = inst_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    inst_valid_d = 1'b0;
    inst_d       = inst_q;
    fill_en      = 1'b0;
    if (rdy) begin
      unique case (state_q)
        IDLE: begin
          // A flushed fetch is stale, so neither answer it nor start a refill for it.
          if (bus.IF_valid && !clear) begin
            if (hit) begin
              inst_valid_d = 1'b1;
              inst_d       = data_mem[req_idx];
            end else begin
              addr_d  = {bus.IF_addr[31:2], 2'b00};
              state_d = MISS;
            end
          end
        end
        MISS: begin
          if (bus.MemCtrl_inst_valid) begin
            fill_en = 1'b1;
            state_d = IDLE;
            if (MISS_FORWARD && !clear) begin
              inst_valid_d = 1'b1;
              inst_d       = bus.MemCtrl_inst;
            end
          end else if (clear) begin
            state_d = ABORT;
          end
        end
        ABORT: begin
          if (bus.MemCtrl_inst_valid) begin
            fill_en = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      if (fill_en) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill_en && !rst) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= bus.MemCtrl_inst;
    end
  end
endmodule

// File: tb/tb_inst_cache.sv
// Directed, table-driven bench for inst_cache: each row is one clock cycle of
// stimulus with the expected request (before the edge) and response (after it).
module tb_inst_cache;
  logic clk = 1'b0;
  logic rst, rdy, clear;

`ifdef ICACHE_MISS_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  inst_cache_if bus();

  inst_cache #(.ICACHE_INDEX_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .rdy  (rdy),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        clr;
    logic        v;
    logic [31:0] addr;
    logic        mv;
    logic [31:0] mdata;
    logic        e_rv;
    logic        e_iv;
    logic        e_fwd;
    logic [31:0] e_inst;
    logic [31:0] e_maddr;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit c, bit v, logic [31:0] a, bit mv, logic [31:0] md,
                              bit e_rv, bit e_iv, bit e_fwd, logic [31:0] e_inst,
                              logic [31:0] e_maddr);
    vec_t t;
    t.rdy = r; t.clr = c; t.v = v; t.addr = a; t.mv = mv; t.mdata = md;
    t.e_rv = e_rv; t.e_iv = e_iv; t.e_fwd = e_fwd; t.e_inst = e_inst; t.e_maddr = e_maddr;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Entered and left at a negedge; one clock cycle per call.
  task automatic apply(int idx, vec_t t);
    logic exp_iv;
    rdy = t.rdy; clear = t.clr;
    bus.IF_valid = t.v; bus.IF_addr = t.addr;
    bus.MemCtrl_inst_valid = t.mv; bus.MemCtrl_inst = t.mdata;
    #1;
    chk($sformatf("row%0d read_valid", idx), {31'b0, bus.MemCtrl_inst_read_valid}, {31'b0, t.e_rv});
    @(posedge clk);
    #1;
    exp_iv = t.e_iv | (t.e_fwd & FWD);
    chk($sformatf("row%0d inst_valid", idx), {31'b0, bus.IF_inst_valid}, {31'b0, exp_iv});
    if (exp_iv) chk($sformatf("row%0d inst", idx), bus.IF_inst, t.e_inst);
    chk($sformatf("row%0d mem_addr", idx), bus.MemCtrl_inst_addr, t.e_maddr);
    $display("row%0d rdy=%0b clr=%0b v=%0b addr=%h mv=%0b -> rv=%0b iv=%0b inst=%h maddr=%h",
             idx, t.rdy, t.clr, t.v, t.addr, t.mv, bus.MemCtrl_inst_read_valid,
             bus.IF_inst_valid, bus.IF_inst, bus.MemCtrl_inst_addr);
    @(negedge clk);
  endtask

  initial begin
    //               rdy clr v  addr          mv data           rv iv fwd inst          maddr
    vecs.push_back(mk(1, 0, 1, 32'h0000_0100, 0, 32'h0,          0, 0, 0, 32'h0,         32'h100));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0100, 0, 32'h0,          1, 0, 0, 32'h0,         32'h100));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0100, 1, 32'h0000_0013,  0, 0, 1, 32'h13,        32'h100));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0100, 0, 32'h0,          0, 1, 0, 32'h13,        32'h100));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0100, 0, 32'h0,          0, 1, 0, 32'h13,        32'h100));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0100, 0, 32'h0,          0, 1, 0, 32'h13,        32'h100));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0500, 0, 32'h0,          0, 0, 0, 32'h0,         32'h500));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 32'hAAAA_0001,  0, 0, 1, 32'hAAAA_0001, 32'h500));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0500, 0, 32'h0,          0, 1, 0, 32'hAAAA_0001, 32'h500));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0100, 0, 32'h0,          0, 0, 0, 32'h0,         32'h100));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 32'h0000_0013,  0, 0, 1, 32'h13,        32'h100));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0200, 0, 32'h0,          0, 0, 0, 32'h0,         32'h200));
    vecs.push_back(mk(1, 1, 0, 32'h0,         0, 32'h0,          1, 0, 0, 32'h0,         32'h200));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0100, 0, 32'h0,          1, 0, 0, 32'h0,         32'h200));
    vecs.push_back(mk(1, 1, 0, 32'h0,         0, 32'h0,          1, 0, 0, 32'h0,         32'h200));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 32'h0000_0022,  0, 0, 0, 32'h0,         32'h200));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0200, 0, 32'h0,          0, 1, 0, 32'h22,        32'h200));
    vecs.push_back(mk(1, 1, 1, 32'h0000_0200, 0, 32'h0,          0, 0, 0, 32'h0,         32'h200));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0300, 0, 32'h0,          0, 0, 0, 32'h0,         32'h300));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 1, 32'h0000_0100, 0, 32'h0,        1, 0, 0, 32'h0,         32'h300));
    vecs.push_back(mk(1, 0, 0, 32'h0,         0, 32'h0,          1, 0, 0, 32'h0,         32'h300));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 32'h0000_0033,  0, 0, 1, 32'h33,        32'h300));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0303, 0, 32'h0,          0, 1, 0, 32'h33,        32'h300));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0400, 0, 32'h0,          0, 0, 0, 32'h0,         32'h400));
    vecs.push_back(mk(1, 1, 0, 32'h0,         1, 32'h0000_0044,  0, 0, 0, 32'h0,         32'h400));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0400, 0, 32'h0,          0, 1, 0, 32'h44,        32'h400));
    vecs.push_back(mk(0, 0, 1, 32'h0000_0400, 0, 32'h0,          0, 0, 0, 32'h0,         32'h400));
    vecs.push_back(mk(1, 0, 1, 32'h0000_0400, 0, 32'h0,          0, 1, 0, 32'h44,        32'h400));

    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    bus.IF_valid = 1'b0; bus.IF_addr = '0;
    bus.MemCtrl_inst_valid = 1'b0; bus.MemCtrl_inst = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset inst_valid", {31'b0, bus.IF_inst_valid}, 32'd0);
    chk("reset inst", bus.IF_inst, 32'd0);
    chk("reset mem_addr", bus.MemCtrl_inst_addr, 32'd0);
    chk("reset read_valid", {31'b0, bus.MemCtrl_inst_read_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) apply(i, vecs[i]);

    // Reset mid-refill, with rdy low to confirm reset wins; the late strobe must be ignored.
    apply(100, mk(1, 0, 1, 32'h0000_0600, 0, 32'h0, 0, 0, 0, 32'h0, 32'h600));
    rst = 1'b1; rdy = 1'b0; bus.IF_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("midmiss reset mem_addr", bus.MemCtrl_inst_addr, 32'd0);
    chk("midmiss reset inst_valid", {31'b0, bus.IF_inst_valid}, 32'd0);
    chk("midmiss reset read_valid", {31'b0, bus.MemCtrl_inst_read_valid}, 32'd0);
    $display("reset mid-miss -> rv=%0b iv=%0b maddr=%h",
             bus.MemCtrl_inst_read_valid, bus.IF_inst_valid, bus.MemCtrl_inst_addr);
    @(negedge clk);
    rst = 1'b0; rdy = 1'b1;
    apply(101, mk(1, 0, 0, 32'h0,         1, 32'h0000_0066, 0, 0, 0, 32'h0,  32'h0));
    apply(102, mk(1, 0, 1, 32'h0000_0200, 0, 32'h0,         0, 0, 0, 32'h0,  32'h200));
    apply(103, mk(1, 0, 0, 32'h0,         1, 32'h0000_0022, 0, 0, 1, 32'h22, 32'h200));
    apply(104, mk(1, 0, 1, 32'h0000_0200, 0, 32'h0,         0, 1, 0, 32'h22, 32'h200));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
